clk_supervisor: RTL and testbench

CLK_SUPERVISOR -- requirements
Module: clk_supervisor

---
 rtl/clk_supervisor_pkg.sv | 31 +++
 rtl/ce_accum.sv | 57 +++++
 rtl/clk_supervisor.sv | 159 +++++++++++++++
 tb/tb_clk_supervisor.sv | 340 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/clk_supervisor_pkg.sv
// Shared definitions for the clock supervisor: FSM state encoding,
// default parameter values and the counter-width helper.
package clk_supervisor_pkg;

    typedef enum logic [1:0] {
        ST_DCM_RST   = 2'd0,
        ST_WAIT_LOCK = 2'd1,
        ST_RUN       = 2'd2,
        ST_FAIL      = 2'd3
    } state_t;

    localparam int DEF_NCH          = 2;
    localparam int DEF_W            = 16;
    localparam int DEF_RST_CYCLES   = 8;
    localparam int DEF_LOCK_TIMEOUT = 1024;
    localparam int DEF_MAX_RETRY    = 3;

    // Ceiling log2, never less than 1 so a counter always has at least one bit.
    function automatic int clog2(input int value);
        int bits;
        int rem;
        bits = 0;
        rem  = value - 1;
        while (rem > 0) begin
            bits = bits + 1;
            rem  = rem >> 1;
        end
        return (bits < 1) ? 1 : bits;
    endfunction

endpackage

// File: rtl/ce_accum.sv
// One fractional clock-enable channel: a phase accumulator that emits
// mul pulses for every div enabled cycles, with clamping at the edges.
module ce_accum
    import clk_supervisor_pkg::*;
#(
    parameter int W = DEF_W
) (
    input  logic         clk_in,
    input  logic         rst,
    input  logic         en,
    input  logic         clr,
    input  logic [W-1:0] mul,
    input  logic [W-1:0] div,
    output logic         ce
);

    logic [W:0] acc_reg;
    logic [W:0] acc_next;
    logic [W:0] acc_sum;
    logic       hit;

    // Next accumulator value and pulse decision for an enabled cycle.
    // With mul < div the accumulator stays below div, so W+1 bits never
    // overflow; mul >= div is clamped to a pulse every cycle with acc held.
    always_comb begin
        acc_sum  = acc_reg + {1'b0, mul};
        hit      = 1'b0;
        acc_next = acc_reg;
        if (div == '0 || mul == '0) begin
            hit      = 1'b0;
            acc_next = acc_reg;
        end else if (mul >= div) begin
            hit      = 1'b1;
            acc_next = acc_reg;
        end else if (acc_sum >= {1'b0, div}) begin
            hit      = 1'b1;
            acc_next = acc_sum - {1'b0, div};
        end else begin
            hit      = 1'b0;
            acc_next = acc_sum;
        end
    end

    // Accumulator and registered pulse; clear wins over an update.
    always_ff @(posedge clk_in) begin
        if (rst || clr) begin
            acc_reg <= '0;
            ce      <= 1'b0;
        end else if (en) begin
            acc_reg <= acc_next;
            ce      <= hit;
        end else begin
            ce      <= 1'b0;
        end
    end

endmodule

// File: rtl/clk_supervisor.sv
// Clock supervisor: sequences the external DCM reset, waits for lock
// with bounded retries, and generates per-channel fractional clock
// enables only while the DCM is locked.
module clk_supervisor
    import clk_supervisor_pkg::*;
#(
    parameter int NCH          = DEF_NCH,
    parameter int W            = DEF_W,
    parameter int RST_CYCLES   = DEF_RST_CYCLES,
    parameter int LOCK_TIMEOUT = DEF_LOCK_TIMEOUT,
    parameter int MAX_RETRY    = DEF_MAX_RETRY
) (
    input  logic                              clk_in,
    input  logic                              rst,
    input  logic                              dcm_locked,
    output logic                              dcm_rst,
    input  logic [NCH*W-1:0]                  ratio_mul,
    input  logic [NCH*W-1:0]                  ratio_div,
    input  logic                              ratio_load,
    output logic [NCH-1:0]                    ce_out,
    output logic                              ready,
    output logic                              fail,
    output logic [clog2(MAX_RETRY+1)-1:0]     retry_cnt
);

    localparam int RC_W    = clog2(MAX_RETRY + 1);
    localparam int CNT_MAX = (RST_CYCLES > LOCK_TIMEOUT) ? RST_CYCLES : LOCK_TIMEOUT;
    localparam int CNT_W   = clog2(CNT_MAX);

    localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] WAIT_LAST   = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [RC_W-1:0]  RETRY_LIMIT = RC_W'(MAX_RETRY);

    logic [1:0]       sync_reg;
    logic             lk_s;
    state_t           state_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic [RC_W-1:0]  retry_reg;
    logic [RC_W-1:0]  retry_inc;
    logic             dcm_rst_reg;
    logic             ready_reg;
    logic             fail_reg;
    logic [NCH*W-1:0] mul_reg;
    logic [NCH*W-1:0] div_reg;
    logic             enter_run;
    logic             stay_run;
    logic             acc_clr;

    assign lk_s      = sync_reg[1];
    assign retry_inc = retry_reg + RC_W'(1);

    // Accumulators advance only on cycles that remain in RUN; a lock-loss
    // cycle already counts as leaving RUN so no stray pulse follows it.
    assign enter_run = (state_reg == ST_WAIT_LOCK) && lk_s;
    assign stay_run  = (state_reg == ST_RUN) && lk_s;
    assign acc_clr   = ratio_load || enter_run;

    assign dcm_rst   = dcm_rst_reg;
    assign ready     = ready_reg;
    assign fail      = fail_reg;
    assign retry_cnt = retry_reg;

    // Two-flop LOCKED synchronizer; held clear while the DCM is in reset
    // because LOCKED from a DCM under reset carries no information.
    always_ff @(posedge clk_in) begin
        if (rst || dcm_rst_reg) begin
            sync_reg <= 2'b00;
        end else begin
            sync_reg <= {sync_reg[0], dcm_locked};
        end
    end

    // Shadow ratio registers, loadable in any state.
    always_ff @(posedge clk_in) begin
        if (rst) begin
            mul_reg <= '0;
            div_reg <= '0;
        end else if (ratio_load) begin
            mul_reg <= ratio_mul;
            div_reg <= ratio_div;
        end
    end

    // Supervisor FSM with registered status outputs.
    always_ff @(posedge clk_in) begin
        if (rst) begin
            state_reg   <= ST_DCM_RST;
            cnt_reg     <= '0;
            retry_reg   <= '0;
            dcm_rst_reg <= 1'b1;
            ready_reg   <= 1'b0;
            fail_reg    <= 1'b0;
        end else begin
            case (state_reg)
                ST_DCM_RST: begin
                    if (cnt_reg == RST_LAST) begin
                        state_reg   <= ST_WAIT_LOCK;
                        cnt_reg     <= '0;
                        dcm_rst_reg <= 1'b0;
                    end else begin
                        cnt_reg <= cnt_reg + CNT_W'(1);
                    end
                end
                ST_WAIT_LOCK: begin
                    if (lk_s) begin
                        state_reg <= ST_RUN;
                        cnt_reg   <= '0;
                        ready_reg <= 1'b1;
                    end else if (cnt_reg == WAIT_LAST) begin
                        cnt_reg     <= '0;
                        retry_reg   <= retry_inc;
                        dcm_rst_reg <= 1'b1;
                        if (retry_inc == RETRY_LIMIT) begin
                            state_reg <= ST_FAIL;
                            fail_reg  <= 1'b1;
                        end else begin
                            state_reg <= ST_DCM_RST;
                        end
                    end else begin
                        cnt_reg <= cnt_reg + CNT_W'(1);
                    end
                end
                ST_RUN: begin
                    if (!lk_s) begin
                        state_reg   <= ST_DCM_RST;
                        cnt_reg     <= '0;
                        retry_reg   <= '0;
                        dcm_rst_reg <= 1'b1;
                        ready_reg   <= 1'b0;
                    end
                end
                default: begin
                    // FAIL is terminal until rst; keep the DCM held in reset.
                    state_reg   <= ST_FAIL;
                    dcm_rst_reg <= 1'b1;
                    fail_reg    <= 1'b1;
                    ready_reg   <= 1'b0;
                end
            endcase
        end
    end

    generate
        for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
            ce_accum #(
                .W(W)
            ) u_accum (
                .clk_in (clk_in),
                .rst    (rst),
                .en     (stay_run),
                .clr    (acc_clr),
                .mul    (mul_reg[gi*W +: W]),
                .div    (div_reg[gi*W +: W]),
                .ce     (ce_out[gi])
            );
        end
    endgenerate

endmodule

// File: tb/tb_clk_supervisor.sv
// Self-checking bench for clk_supervisor: randomized lock/ratio stimulus
// compared every cycle against a behavioural model, plus directed
// timing checks on the main scenarios.
module tb_clk_supervisor;

    localparam int NCH          = 2;
    localparam int W            = 16;
    localparam int RST_CYCLES   = 8;
    localparam int LOCK_TIMEOUT = 1024;
    localparam int MAX_RETRY    = 3;

    localparam int P_RST  = 0;
    localparam int P_WAIT = 1;
    localparam int P_RUN  = 2;
    localparam int P_FAIL = 3;

    logic             clk_in;
    logic             rst;
    logic             dcm_locked;
    logic             dcm_rst;
    logic [NCH*W-1:0] ratio_mul;
    logic [NCH*W-1:0] ratio_div;
    logic             ratio_load;
    logic [NCH-1:0]   ce_out;
    logic             ready;
    logic             fail;
    logic [1:0]       retry_cnt;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    // Behavioural model state
    int m_phase;
    int m_age;
    int m_retry;
    bit m_s1;
    bit m_s2;
    int m_mul [NCH];
    int m_div [NCH];
    int m_k   [NCH];
    bit m_ce  [NCH];

    clk_supervisor #(
        .NCH          (NCH),
        .W            (W),
        .RST_CYCLES   (RST_CYCLES),
        .LOCK_TIMEOUT (LOCK_TIMEOUT),
        .MAX_RETRY    (MAX_RETRY)
    ) dut (
        .clk_in     (clk_in),
        .rst        (rst),
        .dcm_locked (dcm_locked),
        .dcm_rst    (dcm_rst),
        .ratio_mul  (ratio_mul),
        .ratio_div  (ratio_div),
        .ratio_load (ratio_load),
        .ce_out     (ce_out),
        .ready      (ready),
        .fail       (fail),
        .retry_cnt  (retry_cnt)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s (cycle %0d): got %0h expected %0h", tag, cyc, got, exp);
    endtask

    // k-th enabled step since clear pulses exactly when floor(k*mul/div) advances.
    function automatic bit exp_pulse(input int mul, input int div, input int k);
        longint a;
        longint b;
        if (div == 0 || mul == 0) return 1'b0;
        if (mul >= div) return 1'b1;
        a = (longint'(k) * mul) / div;
        b = (longint'(k - 1) * mul) / div;
        return a != b;
    endfunction

    task automatic model_edge();
        bit lk;
        bit dr;
        bit enter_run;
        bit stay_run;
        if (rst) begin
            m_phase = P_RST;
            m_age   = 1;
            m_retry = 0;
            m_s1    = 0;
            m_s2    = 0;
            for (int c = 0; c < NCH; c++) begin
                m_mul[c] = 0; m_div[c] = 0; m_k[c] = 0; m_ce[c] = 0;
            end
            return;
        end
        lk        = m_s2;
        dr        = (m_phase == P_RST) || (m_phase == P_FAIL);
        enter_run = (m_phase == P_WAIT) && lk;
        stay_run  = (m_phase == P_RUN) && lk;
        for (int c = 0; c < NCH; c++) begin
            if (ratio_load || enter_run) begin
                m_k[c] = 0; m_ce[c] = 0;
            end else if (stay_run) begin
                m_k[c]  = m_k[c] + 1;
                m_ce[c] = exp_pulse(m_mul[c], m_div[c], m_k[c]);
            end else begin
                m_ce[c] = 0;
            end
        end
        if (ratio_load) begin
            for (int c = 0; c < NCH; c++) begin
                m_mul[c] = int'(ratio_mul[c*W +: W]);
                m_div[c] = int'(ratio_div[c*W +: W]);
            end
        end
        if (dr) begin
            m_s1 = 0; m_s2 = 0;
        end else begin
            m_s2 = m_s1; m_s1 = dcm_locked;
        end
        case (m_phase)
            P_RST: begin
                if (m_age >= RST_CYCLES) begin m_phase = P_WAIT; m_age = 1; end
                else m_age++;
            end
            P_WAIT: begin
                if (lk) begin
                    m_phase = P_RUN; m_age = 1;
                end else if (m_age >= LOCK_TIMEOUT) begin
                    m_retry++;
                    m_phase = (m_retry == MAX_RETRY) ? P_FAIL : P_RST;
                    m_age   = 1;
                end else m_age++;
            end
            P_RUN: begin
                if (!lk) begin m_phase = P_RST; m_age = 1; m_retry = 0; end
            end
            default: ;
        endcase
    endtask

    task automatic compare_all();
        logic [NCH-1:0] exp_ce;
        for (int c = 0; c < NCH; c++) exp_ce[c] = m_ce[c];
        check("dcm_rst",   32'(dcm_rst),   32'(m_phase == P_RST || m_phase == P_FAIL));
        check("ready",     32'(ready),     32'(m_phase == P_RUN));
        check("fail",      32'(fail),      32'(m_phase == P_FAIL));
        check("retry_cnt", 32'(retry_cnt), 32'(m_retry));
        check("ce_out",    32'(ce_out),    32'(exp_ce));
    endtask

    task automatic tick();
        @(posedge clk_in);
        model_edge();
        #1;
        ratio_load = 1'b0;
        compare_all();
        cyc++;
    endtask

    task automatic set_ratio(input int ch, input int mul, input int div);
        ratio_mul[ch*W +: W] = W'(mul);
        ratio_div[ch*W +: W] = W'(div);
    endtask

    task automatic rand_ratio(input int ch);
        int cls;
        int d;
        int m;
        cls = int'($urandom_range(0, 5));
        case (cls)
            0: begin d = 0; m = int'($urandom_range(0, 50)); end
            1: begin d = int'($urandom_range(1, 50)); m = 0; end
            2: begin d = int'($urandom_range(1, 50)); m = d; end
            3: begin d = int'($urandom_range(1, 50)); m = int'($urandom_range(d + 1, 65535)); end
            default: begin d = int'($urandom_range(2, 40)); m = int'($urandom_range(1, d - 1)); end
        endcase
        set_ratio(ch, m, d);
    endtask

    bit   rec_dr  [48];
    bit   rec_rdy [48];
    bit   rec_ce0 [48];
    int   first_low, first_ready, first_ce, n_high, ce_sum, cnt, lag, guard, hi;
    int   t1, t2, t3, tf;
    logic [3:0] pat;

    initial begin
        rst = 1'b1; dcm_locked = 1'b0; ratio_load = 1'b0;
        ratio_mul = '0; ratio_div = '0;
        m_phase = P_RST; m_age = 1; m_retry = 0; m_s1 = 0; m_s2 = 0;
        for (int c = 0; c < NCH; c++) begin
            m_mul[c] = 0; m_div[c] = 0; m_k[c] = 0; m_ce[c] = 0;
        end

        // S1: power-up with steady lock, 3/8 on ch0
        dcm_locked = 1'b1;
        tick(); tick();
        rec_dr[0] = dcm_rst; rec_rdy[0] = ready; rec_ce0[0] = ce_out[0];
        rst = 1'b0;
        set_ratio(0, 3, 8);
        set_ratio(1, int'($urandom_range(1, 20)), int'($urandom_range(21, 60)));
        ratio_load = 1'b1;
        for (int i = 1; i < 48; i++) begin
            tick();
            rec_dr[i] = dcm_rst; rec_rdy[i] = ready; rec_ce0[i] = ce_out[0];
        end
        first_low = -1; first_ready = -1; first_ce = -1; n_high = 0; ce_sum = 0;
        for (int i = 0; i < 48; i++) begin
            if (first_low < 0 && !rec_dr[i]) first_low = i;
            if (first_low < 0 && rec_dr[i]) n_high++;
            if (first_ready < 0 && rec_rdy[i]) first_ready = i;
            if (first_ce < 0 && rec_ce0[i]) first_ce = i;
        end
        if (first_ready >= 0)
            for (int i = first_ready + 1; i <= first_ready + 16 && i < 48; i++) ce_sum += int'(rec_ce0[i]);
        check("s1_rst_len",   32'(n_high), 32'(8));
        check("s1_ready_lag", 32'(first_ready - first_low), 32'(3));
        check("s1_first_ce",  32'(first_ce - first_ready), 32'(3));
        check("s1_ce_per16",  32'(ce_sum), 32'(6));

        // ratio change 3/8 -> 1/2 mid-RUN
        set_ratio(0, 1, 2);
        ratio_load = 1'b1;
        tick();
        pat = '0;
        for (int i = 0; i < 4; i++) begin
            tick();
            pat = {pat[2:0], ce_out[0]};
        end
        check("s1_half_pattern", 32'(pat), 32'(4'b0101));

        // ch1 boundaries: div=0, mul=div, mul>div
        set_ratio(1, 9, 0); ratio_load = 1'b1; tick();
        cnt = 0;
        for (int i = 0; i < 10; i++) begin tick(); cnt += int'(ce_out[1]); end
        check("s1_div_zero", 32'(cnt), 32'(0));
        set_ratio(1, 5, 5); ratio_load = 1'b1; tick();
        cnt = 0;
        for (int i = 0; i < 10; i++) begin tick(); cnt += int'(ce_out[1]); end
        check("s1_mul_eq_div", 32'(cnt), 32'(10));
        set_ratio(1, 7, 5); ratio_load = 1'b1; tick();
        cnt = 0;
        for (int i = 0; i < 10; i++) begin tick(); cnt += int'(ce_out[1]); end
        check("s1_mul_gt_div", 32'(cnt), 32'(10));
        $display("scenario power_up_and_ratios done at cycle %0d", cyc);

        // S2: two timeouts, then lock, then a one-cycle lock drop
        rst = 1'b1; tick(); tick();
        rst = 1'b0; dcm_locked = 1'b0;
        guard = 0;
        while (m_retry != 2 && guard < 5000) begin tick(); guard++; end
        check("s2_retry_two", 32'(retry_cnt), 32'(2));
        dcm_locked = 1'b1;
        guard = 0;
        while (m_phase != P_RUN && guard < 200) begin tick(); guard++; end
        check("s2_ready", 32'(ready), 32'(1));
        for (int i = 0; i < 20; i++) tick();
        dcm_locked = 1'b0;
        tick(); lag = 1;
        dcm_locked = 1'b1;
        while (ready && lag < 10) begin tick(); lag++; end
        check("s2_ready_lag", 32'(lag), 32'(3));
        check("s2_retry_clr", 32'(retry_cnt), 32'(0));
        check("s2_ce_off",    32'(ce_out), 32'(0));
        check("s2_dcm_rst",   32'(dcm_rst), 32'(1));
        $display("scenario lock_loss done at cycle %0d", cyc);

        // S3: load coinciding with RUN entry, load with lock loss, then random
        guard = 0;
        while (!(m_phase == P_WAIT && m_s2) && guard < 100) begin tick(); guard++; end
        set_ratio(0, 3, 8); ratio_load = 1'b1;
        tick();
        for (int i = 0; i < 12; i++) tick();
        dcm_locked = 1'b0; tick();
        dcm_locked = 1'b1; tick();
        set_ratio(0, 5, 7); set_ratio(1, 1, 3); ratio_load = 1'b1;
        tick();
        check("s3_loss_with_load", 32'(ready), 32'(0));
        for (int i = 0; i < 800; i++) begin
            rst        = ($urandom_range(0, 399) == 0);
            dcm_locked = ($urandom_range(0, 59) != 0);
            if ($urandom_range(0, 11) == 0) begin
                rand_ratio(0); rand_ratio(1); ratio_load = 1'b1;
            end
            tick();
        end
        rst = 1'b0;
        $display("scenario random done at cycle %0d", cyc);

        // S4: no lock at all -> three timeouts -> FAIL, then reset from FAIL
        rst = 1'b1; dcm_locked = 1'b0; tick();
        rst = 1'b0;
        t1 = -1; t2 = -1; t3 = -1; tf = -1;
        for (int i = 1; i < 3300 && tf < 0; i++) begin
            tick();
            if (t1 < 0 && retry_cnt == 2'd1) t1 = i;
            if (t2 < 0 && retry_cnt == 2'd2) t2 = i;
            if (t3 < 0 && retry_cnt == 2'd3) t3 = i;
            if (tf < 0 && fail) tf = i;
        end
        check("s4_timeout1", 32'(t1), 32'(1 * (RST_CYCLES + LOCK_TIMEOUT)));
        check("s4_timeout2", 32'(t2), 32'(2 * (RST_CYCLES + LOCK_TIMEOUT)));
        check("s4_timeout3", 32'(t3), 32'(3 * (RST_CYCLES + LOCK_TIMEOUT)));
        check("s4_fail_at",  32'(tf), 32'(3 * (RST_CYCLES + LOCK_TIMEOUT)));
        for (int i = 0; i < 30; i++) begin
            dcm_locked = ($urandom_range(0, 1) == 1);
            if ($urandom_range(0, 7) == 0) begin rand_ratio(0); ratio_load = 1'b1; end
            tick();
        end
        check("s4_fail_held",    32'(fail), 32'(1));
        check("s4_dcm_rst_held", 32'(dcm_rst), 32'(1));
        rst = 1'b1; tick();
        check("s4_fail_cleared", 32'(fail), 32'(0));
        rst = 1'b0; dcm_locked = 1'b1; hi = 1;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (dcm_rst) hi++;
            else break;
        end
        check("s4_rerst_len", 32'(hi), 32'(8));
        for (int i = 0; i < 20; i++) tick();
        check("s4_run_again", 32'(ready), 32'(1));
        $display("scenario timeout_fail done at cycle %0d", cyc);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
